dino_game_ctrl: RTL and testbench

Frame-rate game sequencer for the dino game. It owns game state (attract / running / game-over), dino jump physics, obstacle scrolling, speed ramp and BCD score. It advances once per frame on a vsync-derived tick from the VGA timing block. Its outputs configure the sprite/render datapath inside tt_um_uwasic_dinogame, and it takes back a collision pulse from that datapath.

---
 rtl/dino_pkg.sv | 29 ++
 rtl/dino_game_ctrl_bcd.sv | 58 +++++
 rtl/dino_game_ctrl.sv | 235 +++++++++++++++++++++++
 tb/tb_dino_game_ctrl.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dino_pkg.sv
// Shared definitions for the dino game sequencer.
//   game_state_t : top-level game mode, encoded as reported on game_state
//   H_W/X_W/SPD_W: widths of dino height, obstacle x and scroll speed
//   VEL_W        : width of the signed vertical velocity
//   LFSR_TAPS    : feedback mask for the 8-bit Fibonacci LFSR (taps 8,6,5,4)
//   lfsr_next()  : one LFSR step (shift left, feedback into bit 0)
package dino_pkg;

    typedef enum logic [1:0] {
        ATTRACT   = 2'd0,
        RUNNING   = 2'd1,
        GAME_OVER = 2'd2
    } game_state_t;

    localparam int H_W   = 7;
    localparam int X_W   = 10;
    localparam int SPD_W = 4;
    localparam int VEL_W = 6;
    localparam int BCD_W = 16;

    // Taps 8,6,5,4 counted from 1 map to bits 7,5,4,3.
    localparam logic [7:0] LFSR_TAPS = 8'hB8;
    localparam logic [7:0] LFSR_SEED = 8'hA5;

    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        return {s[6:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/dino_game_ctrl_bcd.sv
// Four-digit BCD up-counter used for the game score.
//   clk, rst       : clock and synchronous active-high reset
//   clr            : synchronous clear (wins over inc)
//   inc            : count enable, one increment per enabled cycle
//   value          : BCD count, digit 3 in [15:12]; sticks at 9999
//   hundreds_wrap  : combinational, high when the pending increment turns
//                    the low two digits from 99 to 00 (drives the speed ramp)
module bcd_counter4
    import dino_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [BCD_W-1:0] value,
    output logic             hundreds_wrap
);

    logic [BCD_W-1:0] value_reg;
    logic [BCD_W-1:0] value_next;
    logic [3:0]       is_nine;
    logic [3:0]       carry;
    logic             saturated;
    logic             count_en;

    assign saturated = (value_reg == 16'h9999);
    assign count_en  = inc & ~clr & ~saturated;

    // carry[d] means digit d receives an increment this cycle.
    always_comb begin
        carry[0] = count_en;
        carry[1] = count_en & is_nine[0];
        carry[2] = count_en & is_nine[0] & is_nine[1];
        carry[3] = count_en & is_nine[0] & is_nine[1] & is_nine[2];
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_digit
            assign is_nine[gi] = (value_reg[gi*4 +: 4] == 4'd9);
            assign value_next[gi*4 +: 4] =
                !carry[gi]  ? value_reg[gi*4 +: 4] :
                is_nine[gi] ? 4'd0 :
                              value_reg[gi*4 +: 4] + 4'd1;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            value_reg <= '0;
        end else begin
            value_reg <= value_next;
        end
    end

    assign value         = value_reg;
    assign hundreds_wrap = carry[2];

endmodule

// File: rtl/dino_game_ctrl.sv
// Frame-rate game sequencer for the dino game. Advances one frame per
// frame_tick: game mode, jump physics, obstacle scroll, speed ramp, score.
//   clk, rst    : pixel clock, synchronous active-high reset
//   frame_tick  : one-cycle pulse at start of vertical blanking
//   jump_btn    : synchronised jump level (rising edge = press)
//   duck_btn    : synchronised duck level
//   collision   : one-cycle overlap pulse from the renderer
//   game_state  : 0 attract, 1 running, 2 game over
//   dino_h      : dino height above ground (px)
//   dino_duck   : duck pose
//   obs_x       : obstacle left x
//   obs_type    : obstacle sprite select
//   speed       : scroll speed (px/frame)
//   score       : 4-digit BCD score
module dino_game_ctrl
    import dino_pkg::*;
#(
    parameter int JUMP_VEL   = 12,
    parameter int GRAVITY    = 1,
    parameter int OBS_START  = 640,
    parameter int SCORE_DIV  = 6,
    parameter int SPEED_INIT = 4,
    parameter int SPEED_MAX  = 12,
    parameter int HOLDOFF    = 30
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             frame_tick,
    input  logic             jump_btn,
    input  logic             duck_btn,
    input  logic             collision,
    output logic [1:0]       game_state,
    output logic [H_W-1:0]   dino_h,
    output logic             dino_duck,
    output logic [X_W-1:0]   obs_x,
    output logic [1:0]       obs_type,
    output logic [SPD_W-1:0] speed,
    output logic [BCD_W-1:0] score
);

    localparam int SUM_W  = H_W + 1;
    localparam int DIV_W  = (SCORE_DIV > 1) ? $clog2(SCORE_DIV) : 1;
    localparam int HOLD_W = $clog2(HOLDOFF + 1);

    localparam logic [H_W-1:0]          JUMP_H      = H_W'(JUMP_VEL);
    localparam logic signed [VEL_W-1:0] VEL0        = VEL_W'(JUMP_VEL - GRAVITY);
    localparam logic signed [VEL_W-1:0] GRAV        = VEL_W'(GRAVITY);
    localparam logic [X_W-1:0]          OBS_RELOAD  = X_W'(OBS_START);
    localparam logic [SPD_W-1:0]        SPEED_RESET = SPD_W'(SPEED_INIT);
    localparam logic [SPD_W-1:0]        SPEED_CAP   = SPD_W'(SPEED_MAX);
    localparam logic [DIV_W-1:0]        DIV_LAST    = DIV_W'(SCORE_DIV - 1);
    localparam logic [HOLD_W-1:0]       HOLD_LOAD   = HOLD_W'(HOLDOFF);

    game_state_t              state_reg;
    logic [H_W-1:0]           h_reg;
    logic signed [VEL_W-1:0]  vel_reg;
    logic                     duck_reg;
    logic [X_W-1:0]           obs_x_reg;
    logic [1:0]               obs_type_reg;
    logic [SPD_W-1:0]         speed_reg;
    logic [DIV_W-1:0]         frame_div_reg;
    logic [HOLD_W-1:0]        holdoff_reg;
    logic                     coll_flag_reg;
    logic                     btn_prev_reg;
    logic                     jump_latch_reg;
    logic [7:0]               lfsr_reg;

    logic                     jump_rise;
    logic                     jump_press;
    logic                     coll_now;
    logic                     running_tick;
    logic                     start_tick;
    logic                     score_inc;
    logic                     score_wrap;
    logic                     obs_reload;
    logic [X_W-1:0]           speed_ext;
    logic [7:0]               lfsr_step;
    logic                     on_ground;
    logic signed [SUM_W-1:0]  h_ext;
    logic signed [SUM_W-1:0]  vel_ext;
    logic signed [SUM_W-1:0]  h_sum;
    logic [H_W-1:0]           h_phys;
    logic signed [VEL_W-1:0]  vel_phys;

    // A press is visible to the tick either from the latch or, if the edge
    // lands on the tick cycle itself, directly from the edge detector.
    assign jump_rise  = jump_btn & ~btn_prev_reg;
    assign jump_press = jump_latch_reg | jump_rise;

    // A collision on the tick cycle still ends the current frame.
    assign coll_now     = coll_flag_reg | (collision & (state_reg == RUNNING));
    assign running_tick = frame_tick & (state_reg == RUNNING) & ~coll_now;

    // Ticks that begin a game: from attract, or after the holdoff expires.
    assign start_tick = frame_tick & jump_press &
                        ((state_reg == ATTRACT) ||
                         ((state_reg == GAME_OVER) && (holdoff_reg == '0)));

    assign score_inc  = running_tick & (frame_div_reg == DIV_LAST);
    assign speed_ext  = {{(X_W-SPD_W){1'b0}}, speed_reg};
    assign obs_reload = (obs_x_reg < speed_ext);
    assign lfsr_step  = lfsr_next(lfsr_reg);
    assign on_ground  = (h_reg == '0) && (vel_reg == '0);

    // Jump physics for a running frame. Height is evaluated in a signed
    // width one bit wider than dino_h so a landing overshoot reads as <= 0.
    always_comb begin
        h_ext    = {1'b0, h_reg};
        vel_ext  = {{(SUM_W-VEL_W){vel_reg[VEL_W-1]}}, vel_reg};
        h_sum    = h_ext + vel_ext;
        h_phys   = h_reg;
        vel_phys = vel_reg;
        if (on_ground) begin
            if (jump_press) begin
                h_phys   = JUMP_H;
                vel_phys = VEL0;
            end
        end else if (h_sum <= 0) begin
            h_phys   = '0;
            vel_phys = '0;
        end else begin
            h_phys   = h_sum[H_W-1:0];
            vel_phys = vel_reg - GRAV;
        end
    end

    bcd_counter4 u_score (
        .clk           (clk),
        .rst           (rst),
        .clr           (start_tick),
        .inc           (score_inc),
        .value         (score),
        .hundreds_wrap (score_wrap)
    );

    // Per-cycle bookkeeping: button edge latch, collision latch and the LFSR
    // (which free-runs in attract so the obstacle sequence depends on how
    // long the player waited before starting).
    always_ff @(posedge clk) begin
        if (rst) begin
            btn_prev_reg   <= 1'b0;
            jump_latch_reg <= 1'b0;
            coll_flag_reg  <= 1'b0;
            lfsr_reg       <= LFSR_SEED;
        end else begin
            btn_prev_reg <= jump_btn;
            if (frame_tick) begin
                jump_latch_reg <= 1'b0;
            end else if (jump_rise) begin
                jump_latch_reg <= 1'b1;
            end
            if (frame_tick) begin
                coll_flag_reg <= 1'b0;
            end else if (collision && (state_reg == RUNNING)) begin
                coll_flag_reg <= 1'b1;
            end
            if ((state_reg == ATTRACT) || (running_tick && obs_reload)) begin
                lfsr_reg <= lfsr_step;
            end
        end
    end

    // Game FSM; every visible output is a register updated here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ATTRACT;
            h_reg         <= '0;
            vel_reg       <= '0;
            duck_reg      <= 1'b0;
            obs_x_reg     <= OBS_RELOAD;
            obs_type_reg  <= 2'd0;
            speed_reg     <= SPEED_RESET;
            frame_div_reg <= '0;
            holdoff_reg   <= '0;
        end else if (frame_tick) begin
            case (state_reg)
                ATTRACT: begin
                    if (jump_press) begin
                        state_reg     <= RUNNING;
                        obs_x_reg     <= OBS_RELOAD;
                        speed_reg     <= SPEED_RESET;
                        frame_div_reg <= '0;
                    end
                end
                RUNNING: begin
                    if (coll_now) begin
                        state_reg   <= GAME_OVER;
                        holdoff_reg <= HOLD_LOAD;
                    end else begin
                        h_reg    <= h_phys;
                        vel_reg  <= vel_phys;
                        duck_reg <= duck_btn & (h_phys == '0);
                        if (obs_reload) begin
                            obs_x_reg    <= OBS_RELOAD;
                            obs_type_reg <= lfsr_step[1:0];
                        end else begin
                            obs_x_reg <= obs_x_reg - speed_ext;
                        end
                        if (frame_div_reg == DIV_LAST) begin
                            frame_div_reg <= '0;
                        end else begin
                            frame_div_reg <= frame_div_reg + 1'b1;
                        end
                        if (score_wrap && (speed_reg < SPEED_CAP)) begin
                            speed_reg <= speed_reg + 1'b1;
                        end
                    end
                end
                GAME_OVER: begin
                    if (holdoff_reg != '0) begin
                        holdoff_reg <= holdoff_reg - 1'b1;
                    end else if (jump_press) begin
                        state_reg     <= RUNNING;
                        obs_x_reg     <= OBS_RELOAD;
                        speed_reg     <= SPEED_RESET;
                        h_reg         <= '0;
                        vel_reg       <= '0;
                        frame_div_reg <= '0;
                    end
                end
                default: begin
                    state_reg <= ATTRACT;
                end
            endcase
        end
    end

    assign game_state = state_reg;
    assign dino_h     = h_reg;
    assign dino_duck  = duck_reg;
    assign obs_x      = obs_x_reg;
    assign obs_type   = obs_type_reg;
    assign speed      = speed_reg;

endmodule

// File: tb/tb_dino_game_ctrl.sv
module tb_dino_game_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        frame_tick;
    logic        jump_btn;
    logic        duck_btn;
    logic        collision;
    logic [1:0]  game_state;
    logic [6:0]  dino_h;
    logic        dino_duck;
    logic [9:0]  obs_x;
    logic [1:0]  obs_type;
    logic [3:0]  speed;
    logic [15:0] score;

    logic        b_clr;
    logic        b_inc;
    logic [15:0] b_val;
    logic        b_wrap;

    always #20 clk = ~clk;

    dino_game_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .frame_tick (frame_tick),
        .jump_btn   (jump_btn),
        .duck_btn   (duck_btn),
        .collision  (collision),
        .game_state (game_state),
        .dino_h     (dino_h),
        .dino_duck  (dino_duck),
        .obs_x      (obs_x),
        .obs_type   (obs_type),
        .speed      (speed),
        .score      (score)
    );

    bcd_counter4 u_bcd (
        .clk           (clk),
        .rst           (rst),
        .clr           (b_clr),
        .inc           (b_inc),
        .value         (b_val),
        .hundreds_wrap (b_wrap)
    );

    typedef struct packed {
        logic [1:0]  st;
        logic [6:0]  h;
        logic        duck;
        logic [9:0]  ox;
        logic [1:0]  ty;
        logic [3:0]  sp;
        logic [15:0] sc;
    } exp_t;

    exp_t sb[$];

    int checks = 0;
    int errors = 0;

    // Reference game state, integer arithmetic
    int         m_state, m_h, m_v, m_ox, m_spd, m_score, m_div, m_hold;
    logic       m_duck;
    logic [1:0] m_ty;
    logic [7:0] m_lfsr;
    int         run_ticks = 0;
    bit         jp_pend = 0;
    bit         coll_pend = 0;

    bit tb_attract = 0;
    int attract_steps = 0;
    always @(posedge clk) if (!rst && tb_attract) attract_steps <= attract_steps + 1;

    function automatic logic [7:0] lfsr_step(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    function automatic logic [15:0] to_bcd(input int s);
        return {4'(s / 1000 % 10), 4'(s / 100 % 10), 4'(s / 10 % 10), 4'(s % 10)};
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_h = 0; m_v = 0; m_duck = 1'b0; m_ox = 640; m_ty = 2'd0;
        m_spd = 4; m_score = 0; m_div = 0; m_hold = 0;
    endtask

    task automatic model_tick();
        case (m_state)
            0: if (jp_pend) begin
                m_state = 1; m_score = 0; m_spd = 4; m_ox = 640; m_div = 0;
            end
            1: if (coll_pend) begin
                m_state = 2; m_hold = 30;
            end else begin
                run_ticks++;
                if (m_h == 0 && m_v == 0) begin
                    if (jp_pend) begin m_h = 12; m_v = 11; end
                end else if (m_h + m_v <= 0) begin
                    m_h = 0; m_v = 0;
                end else begin
                    m_h = m_h + m_v; m_v = m_v - 1;
                end
                m_duck = duck_btn && (m_h == 0);
                if (m_ox < m_spd) begin
                    m_ox = 640; m_lfsr = lfsr_step(m_lfsr); m_ty = m_lfsr[1:0];
                end else begin
                    m_ox = m_ox - m_spd;
                end
                m_div++;
                if (m_div == 6) begin
                    m_div = 0;
                    if (m_score < 9999) begin
                        m_score++;
                        if (m_score % 100 == 0 && m_spd < 12) m_spd++;
                    end
                end
            end
            default: if (m_hold > 0) begin
                m_hold--;
            end else if (jp_pend) begin
                m_state = 1; m_score = 0; m_spd = 4; m_ox = 640; m_h = 0; m_v = 0; m_div = 0;
            end
        endcase
    endtask

    task automatic push_expect();
        exp_t e;
        e.st = 2'(m_state); e.h = 7'(m_h); e.duck = m_duck; e.ox = 10'(m_ox);
        e.ty = m_ty; e.sp = 4'(m_spd); e.sc = to_bcd(m_score);
        sb.push_back(e);
    endtask

    task automatic compare_outputs(input string tag);
        exp_t e;
        e = sb.pop_front();
        chk({tag, "/state"}, 16'(game_state), 16'(e.st));
        chk({tag, "/dino_h"}, 16'(dino_h), 16'(e.h));
        chk({tag, "/duck"}, 16'(dino_duck), 16'(e.duck));
        chk({tag, "/obs_x"}, 16'(obs_x), 16'(e.ox));
        chk({tag, "/obs_type"}, 16'(obs_type), 16'(e.ty));
        chk({tag, "/speed"}, 16'(speed), 16'(e.sp));
        chk({tag, "/score"}, score, e.sc);
    endtask

    task automatic do_tick(input string tag);
        model_tick();
        push_expect();
        @(negedge clk) frame_tick = 1'b1;
        @(negedge clk) frame_tick = 1'b0;
        jp_pend = 0;
        coll_pend = 0;
        compare_outputs(tag);
    endtask

    task automatic press();
        @(negedge clk) jump_btn = 1'b1;
        @(negedge clk) jump_btn = 1'b0;
        jp_pend = 1;
    endtask

    initial begin
        int wraps;
        rst = 1'b1; frame_tick = 1'b0; jump_btn = 1'b0; duck_btn = 1'b0;
        collision = 1'b0; b_clr = 1'b0; b_inc = 1'b0;
        model_reset();
        m_lfsr = 8'hA5;
        repeat (3) @(negedge clk);
        push_expect();
        compare_outputs("reset");
        rst = 1'b0;
        tb_attract = 1;
        $display("step: idle in attract");
        repeat (5) do_tick("idle");

        $display("step: start game with held jump");
        @(negedge clk) jump_btn = 1'b1;
        jp_pend = 1;
        do_tick("start");
        tb_attract = 0;
        m_lfsr = 8'hA5;
        repeat (attract_steps) m_lfsr = lfsr_step(m_lfsr);
        duck_btn = 1'b1;
        repeat (2) do_tick("hold");
        jump_btn = 1'b0;

        $display("step: jump arc");
        press();
        for (int t = 1; t <= 25; t++) begin
            if (t == 5) press();
            do_tick("jump");
            if (t == 1)  chk("jump_first", 16'(dino_h), 16'd12);
            if (t == 12) chk("jump_peak", 16'(dino_h), 16'd78);
            if (t == 25) chk("jump_land", 16'(dino_h), 16'd0);
        end
        duck_btn = 1'b0;

        $display("step: run to 600 frames");
        while (run_ticks < 600) do_tick("run");
        chk("score_600", score, 16'h0100);
        chk("speed_600", 16'(speed), 16'd5);

        $display("step: collision and holdoff");
        @(negedge clk) collision = 1'b1;
        @(negedge clk) collision = 1'b0;
        coll_pend = 1;
        @(negedge clk);
        do_tick("collide");
        chk("game_over", 16'(game_state), 16'd2);
        for (int t = 1; t <= 30; t++) begin
            if (t == 10) press();
            do_tick("holdoff");
        end
        chk("still_over", 16'(game_state), 16'd2);
        press();
        do_tick("restart");
        chk("restarted", 16'(game_state), 16'd1);
        chk("restart_score", score, 16'h0000);

        $display("step: speed ramp to ceiling");
        repeat (5460) do_tick("ramp");
        chk("speed_cap", 16'(speed), 16'd12);
        chk("score_910", score, 16'h0910);

        $display("step: reset mid-jump");
        press();
        repeat (4) do_tick("jump2");
        chk("midjump_h", 16'(dino_h), 16'd42);
        @(negedge clk) rst = 1'b1;
        model_reset();
        push_expect();
        @(negedge clk);
        compare_outputs("midjump_rst");
        rst = 1'b0;

        $display("step: score counter saturation");
        @(negedge clk) b_clr = 1'b1;
        @(negedge clk) b_clr = 1'b0;
        chk("bcd_clear", b_val, 16'h0000);
        wraps = 0;
        b_inc = 1'b1;
        for (int i = 0; i < 9998; i++) begin
            #1;
            if (b_wrap) wraps++;
            @(negedge clk);
        end
        chk("bcd_9998", b_val, 16'h9998);
        for (int i = 0; i < 12; i++) begin
            #1;
            if (b_wrap) wraps++;
            @(negedge clk);
        end
        b_inc = 1'b0;
        chk("bcd_sat", b_val, 16'h9999);
        chk("bcd_wraps", 16'(wraps), 16'd99);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
